// File: rtl/pipe_pkg.sv
// Shared types for the pipeline scheduler: FSM state encodings, operand
// forwarding codes and the register-index match helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LD_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  // Register 0 is hard-wired, so it never participates in a dependency.
  function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
    return (a != 4'd0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_sched_if.sv
// Pipeline-facing bundle of the scheduler: decoded hazard information from
// DR/EX/MEM flows in, stage enables, flushes and operand selects flow out.
// The bundle carries no valid/ready handshake: every field is a level,
// sampled by the scheduler every cycle and acted on in the same cycle;
// the outputs are purely combinational on the current inputs and state.
interface pipe_sched_if;
  logic [3:0] dr_ra1;
  logic [3:0] dr_ra2;
  logic       dr_use1;
  logic       dr_use2;
  logic       dr_jmp;
  logic [3:0] ex_wa3;
  logic       ex_we3;
  logic       ex_read;
  logic       ex_br_taken;
  logic [3:0] mem_wa3;
  logic       mem_we3;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_en;
  logic       if_dr_en;
  logic       pipe_en;
  logic       flush_if;
  logic       flush_dr;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Pipeline datapath side: supplies decode info, consumes controls.
  modport master (
    output dr_ra1, dr_ra2, dr_use1, dr_use2, dr_jmp,
    output ex_wa3, ex_we3, ex_read, ex_br_taken,
    output mem_wa3, mem_we3, mem_req, mem_ack,
    input  pc_en, if_dr_en, pipe_en, flush_if, flush_dr, fwd_a, fwd_b
  );

  // Scheduler side.
  modport slave (
    input  dr_ra1, dr_ra2, dr_use1, dr_use2, dr_jmp,
    input  ex_wa3, ex_we3, ex_read, ex_br_taken,
    input  mem_wa3, mem_we3, mem_req, mem_ack,
    output pc_en, if_dr_en, pipe_en, flush_if, flush_dr, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_sched_hazard_cmp.sv
// Per-operand dependency check: picks the forwarding source for one DR
// source register and flags a load-use hazard on it.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [3:0] ra,
  input  logic       use_ra,
  input  logic [3:0] ex_wa3,
  input  logic       ex_we3,
  input  logic       ex_read,
  input  logic [3:0] mem_wa3,
  input  logic       mem_we3,
  output fwd_t       fwd,
  output logic       load_use
);

  // Youngest producer wins; a load in EX has no ALU result to forward yet.
  always_comb begin
    fwd      = FWD_RF;
    load_use = use_ra & ex_read & ex_we3 & reg_match(ex_wa3, ra);
    if (use_ra && ex_we3 && !ex_read && reg_match(ex_wa3, ra)) begin
      fwd = FWD_EX;
    end else if (use_ra && mem_we3 && reg_match(mem_wa3, ra)) begin
      fwd = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Pipeline scheduler: stalls, flushes and forwarding selects for a 5-stage
// pipeline, with data-memory wait handling, a wait timeout and performance
// counters. Per-cycle priority: memory wait, taken branch, load-use, jump.
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_sched_if.slave      bus,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  fwd_t              fwd_a_c;
  fwd_t              fwd_b_c;
  logic              lu_a;
  logic              lu_b;
  logic              load_use;
  logic              mem_wait;
  logic              pc_en_c;
  logic              if_dr_en_c;
  logic              pipe_en_c;
  logic              flush_if_c;
  logic              flush_dr_c;

  hazard_cmp u_cmp_a (
    .ra       (bus.dr_ra1),
    .use_ra   (bus.dr_use1),
    .ex_wa3   (bus.ex_wa3),
    .ex_we3   (bus.ex_we3),
    .ex_read  (bus.ex_read),
    .mem_wa3  (bus.mem_wa3),
    .mem_we3  (bus.mem_we3),
    .fwd      (fwd_a_c),
    .load_use (lu_a)
  );

  hazard_cmp u_cmp_b (
    .ra       (bus.dr_ra2),
    .use_ra   (bus.dr_use2),
    .ex_wa3   (bus.ex_wa3),
    .ex_we3   (bus.ex_we3),
    .ex_read  (bus.ex_read),
    .mem_wa3  (bus.mem_wa3),
    .mem_we3  (bus.mem_we3),
    .fwd      (fwd_b_c),
    .load_use (lu_b)
  );

  assign load_use = lu_a | lu_b;
  assign mem_wait = bus.mem_req & ~bus.mem_ack;

  // State register; reset drops any pending memory wait at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and controls. The state only tracks history; outputs depend on
  // the current hazards, so an ack cycle in MEM_WAIT behaves like RUN and any
  // branch/jump held during the wait is re-evaluated on release.
  always_comb begin
    state_d    = ST_RUN;
    pc_en_c    = 1'b1;
    if_dr_en_c = 1'b1;
    pipe_en_c  = 1'b1;
    flush_if_c = 1'b0;
    flush_dr_c = 1'b0;
    if (mem_wait) begin
      pc_en_c    = 1'b0;
      if_dr_en_c = 1'b0;
      pipe_en_c  = 1'b0;
      state_d    = ST_MEM_WAIT;
    end else if (bus.ex_br_taken) begin
      flush_if_c = 1'b1;
      flush_dr_c = 1'b1;
    end else if (load_use) begin
      pc_en_c    = 1'b0;
      if_dr_en_c = 1'b0;
      flush_dr_c = 1'b1;
      state_d    = ST_LD_STALL;
    end else if (bus.dr_jmp) begin
      flush_if_c = 1'b1;
    end
    if (reset) begin
      state_d    = ST_RUN;
      pc_en_c    = 1'b0;
      if_dr_en_c = 1'b0;
      pipe_en_c  = 1'b0;
      flush_if_c = 1'b0;
      flush_dr_c = 1'b0;
    end
  end

  assign bus.pc_en    = pc_en_c;
  assign bus.if_dr_en = if_dr_en_c;
  assign bus.pipe_en  = pipe_en_c;
  assign bus.flush_if = flush_if_c;
  assign bus.flush_dr = flush_dr_c;
  assign bus.fwd_a    = reset ? FWD_RF : fwd_a_c;
  assign bus.fwd_b    = reset ? FWD_RF : fwd_b_c;
  assign state        = state_q;

  // Wait timer: restarts on entry to MEM_WAIT, counts MEM_WAIT cycles and
  // latches a sticky error once the limit is reached; the stall itself goes on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q != ST_MEM_WAIT && state_d == ST_MEM_WAIT) begin
        wait_cnt <= '0;
      end else if (state_q == ST_MEM_WAIT) begin
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) timeout_err <= 1'b1;
      end
    end
  end

  // Saturating performance counters for stalled-PC and flushing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en_c && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_if_c || flush_dr_c) && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
